alu_rotcmp_pipe: RTL and testbench
==================================

# alu_rotcmp_pipe

Parametrised, pipelined successor to the 8-bit combinational rotate/compare ALU. Supports ROL, ROR, unsigned MAX/MIN and optionally signed MAX/MIN over a configurable operand width. Uses a two-stage registered datapath with valid/ready handshakes on input and output, so it can sit between streaming producers and consumers in the datapath. Carry, zero, overflow and illegal-op flags are registered alongside each result.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥2.
- `SHIFT_W`, default 5: width of `shiftValue`.
- `clk`  in  1: single clock; everything updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block can accept a beat this cycle.
- `opcode`  in  4: operation select.
- `input1`, `input2`  in  WIDTH: operands.
- `shiftValue`  in  SHIFT_W: rotate amount.
- `out_valid`  out  1: result beat valid.
- `out_ready`  in  1: consumer accepts the result.
- `result`  out  WIDTH: operation result.
- `carryFlag`, `zeroFlag`, `overFlowFlag`, `illegalOp`  out  1: per-result flags.

## Operation
Opcodes:
- 0 ROL
- 1 ROR
- 2 MAX (unsigned)
- 3 MIN (unsigned)
- 4 SMAX, 5 SMIN (only with the macro)
- All other opcodes are illegal.

Rotate:
- Effective amount is `shiftValue mod WIDTH`.
- Amount 0 returns `input1` unchanged with carry 0.
- ROL carry is the last bit wrapped out of the MSB, i.e. `result[0]`.
- ROR carry is the last bit wrapped out of the LSB, i.e. `result[WIDTH-1]`.
- Overflow is 0.

Compare:
- MAX/MIN return the unsigned larger/smaller operand. Ties return `input2` for MAX and `input1` for MIN.
- SMAX/SMIN compare the operands as two's complement.
- For all compare ops, carry = borrow of `input1 - input2` (unsigned `input1 < input2`), and overflow = signed overflow of `input1 - input2`.

Other flags:
- `zeroFlag` = (result == 0) for every opcode, including illegal ones.
- Illegal opcode: result 0, zeroFlag 1, carry 0, overflow 0, `illegalOp` 1.
- `illegalOp` is 0 for every legal opcode.

Pipeline:
- Stage 1 (S1) registers `opcode`, `input1`, `input2`, `shiftValue` plus a valid bit.
- Stage 2 (S2) registers `result`, the flags and `out_valid`.
- S2 loads when `!out_valid || out_ready`.
- S1 loads when it is empty or S2 loads.
- `in_ready = !s1_valid || (!out_valid || out_ready)`, combinational.
- A beat transfers at a rising edge with valid && ready on that side.

## Timing
- Reset (`rst_n` = 0 at an edge): `s1_valid` = 0, `out_valid` = 0, `result` = 0, all four flags = 0. `in_ready` reads 1 in the first cycle after reset.
- Reset mid-operation discards any beats held in S1 or S2; nothing is emitted for them.
- Latency: a beat accepted at edge k appears on `out_valid`/`result` after edge k+1, assuming no backpressure.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Backpressure: while `out_valid && !out_ready`, `result`, the flags and `out_valid` hold stable. S1 can still absorb exactly one more beat, then `in_ready` drops.
- Full-and-drain in the same cycle: with `out_valid && out_ready && s1_valid && in_valid`, S2 takes S1's beat and S1 takes the new beat. No bubble, no loss.
- Once asserted, `out_valid` is not withdrawn until accepted.
- Input signals are ignored when `in_valid` = 0 or `in_ready` = 0.
- Beats are never reordered or duplicated.

## Configuration
- Macro: `ALU_ROTCMP_SIGNED_EN`.
- Defined: opcodes 4/5 perform SMAX/SMIN as described above.
- Undefined: opcodes 4/5 are illegal (result 0, `illegalOp` 1), and no signed comparator is built.

## Test plan
1. WIDTH=8, ROL `input1`=0x81, `shiftValue`=1 → result 0x03, carry 1, zero 0, overflow 0. Same with `shiftValue`=9 → result 0x03.
2. ROR 0x01 by 1 → result 0x80, carry 1. ROR 0x5A by 0 → result 0x5A, carry 0. ROL 0x00 by 3 → result 0x00, zero 1.
3. MAX 0x7F,0x80 → 0x80, carry 1, overflow 1. MIN same operands → 0x7F. With the macro: SMAX → 0x7F, SMIN → 0x80. Without the macro: opcode 4 → result 0, `illegalOp` 1, zero 1.
4. Stream 8 back-to-back beats with `out_ready` = 1 → 8 results in order, the first one cycle after its acceptance edge, one per cycle after that.
5. Hold `out_ready` = 0 for 4 cycles while `in_valid` = 1 → exactly 2 beats are accepted, `in_ready` = 0 after that, and result/flags stay stable. Release `out_ready` → both results drain in order, with no loss and no duplicate.
6. Drive `rst_n` = 0 for one edge with both stages full → `out_valid` = 0, result 0, flags 0 next cycle, `in_ready` = 1, and no stale beat is emitted afterwards.

Source files
------------

// File: rtl/alu_rotcmp_pipe.sv
// alu_rotcmp_pipe: two-stage valid/ready rotate/compare ALU.
// S1 holds the operand beat and S2 holds the result plus flags.
// Define ALU_ROTCMP_SIGNED_EN to enable SMAX/SMIN on opcodes 4/5.
// Without that macro, opcodes 4/5 are illegal.
module alu_rotcmp_pipe #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  input  logic [SHIFT_W-1:0] shiftValue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carryFlag,
  output logic               zeroFlag,
  output logic               overFlowFlag,
  output logic               illegalOp
);

  localparam logic [3:0] OP_ROL  = 4'd0;
  localparam logic [3:0] OP_ROR  = 4'd1;
  localparam logic [3:0] OP_MAX  = 4'd2;
  localparam logic [3:0] OP_MIN  = 4'd3;
  localparam logic [3:0] OP_SMAX = 4'd4;
  localparam logic [3:0] OP_SMIN = 4'd5;

  // Stage 1 operand registers
  logic               s1_valid_r;
  logic [3:0]         s1_op_r;
  logic [WIDTH-1:0]   s1_a_r;
  logic [WIDTH-1:0]   s1_b_r;
  logic [SHIFT_W-1:0] s1_sh_r;

  // Stage 2 result registers
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r;
  logic               zero_r;
  logic               ovf_r;
  logic               ill_r;

  // Handshake and datapath signals
  logic               s2_load_s;
  logic               s1_load_s;
  logic [31:0]        amt_s;
  logic [WIDTH-1:0]   rol_s;
  logic [WIDTH-1:0]   ror_s;
  logic               amt_zero_s;
  logic               borrow_s;
  logic               b_lt_a_s;
  logic               lt_low_s;
  logic               ovf_sub_s;
  logic [WIDTH-1:0]   res_s;
  logic               carry_s;
  logic               ovf_s;
  logic               ill_s;
  logic               zero_s;

  // S2 may take a new beat when it is empty or its current result is being consumed.
  assign s2_load_s = !out_valid_r || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = s1_load_s;

  // Rotation amount is reduced modulo WIDTH.
  // A shift by the full WIDTH yields zero, which covers the amount-0 case.
  assign amt_s      = 32'(s1_sh_r) % 32'(WIDTH);
  assign amt_zero_s = (amt_s == 32'd0);
  assign rol_s      = (s1_a_r << amt_s) | (s1_a_r >> (32'(WIDTH) - amt_s));
  assign ror_s      = (s1_a_r >> amt_s) | (s1_a_r << (32'(WIDTH) - amt_s));

  // Unsigned compare and signed overflow of input1 - input2.
  // The overflow is derived from the sign bits plus the magnitude compare of the low bits.
  assign borrow_s  = (s1_a_r < s1_b_r);
  assign b_lt_a_s  = (s1_b_r < s1_a_r);
  assign lt_low_s  = (s1_a_r[WIDTH-2:0] < s1_b_r[WIDTH-2:0]);
  assign ovf_sub_s = (s1_a_r[WIDTH-1] && !s1_b_r[WIDTH-1] && lt_low_s) ||
                     (!s1_a_r[WIDTH-1] && s1_b_r[WIDTH-1] && !lt_low_s);

`ifdef ALU_ROTCMP_SIGNED_EN
  logic               sb_lt_a_s;
  assign sb_lt_a_s = ($signed(s1_b_r) < $signed(s1_a_r));
`endif

  // Operation decode: result, carry, overflow and illegal-op for the S1 beat
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    ill_s   = 1'b0;
    case (s1_op_r)
      OP_ROL: begin
        res_s   = rol_s;
        carry_s = amt_zero_s ? 1'b0 : rol_s[0];
      end
      OP_ROR: begin
        res_s   = ror_s;
        carry_s = amt_zero_s ? 1'b0 : ror_s[WIDTH-1];
      end
      OP_MAX: begin
        res_s   = b_lt_a_s ? s1_a_r : s1_b_r;
        carry_s = borrow_s;
        ovf_s   = ovf_sub_s;
      end
      OP_MIN: begin
        res_s   = b_lt_a_s ? s1_b_r : s1_a_r;
        carry_s = borrow_s;
        ovf_s   = ovf_sub_s;
      end
`ifdef ALU_ROTCMP_SIGNED_EN
      OP_SMAX: begin
        res_s   = sb_lt_a_s ? s1_a_r : s1_b_r;
        carry_s = borrow_s;
        ovf_s   = ovf_sub_s;
      end
      OP_SMIN: begin
        res_s   = sb_lt_a_s ? s1_b_r : s1_a_r;
        carry_s = borrow_s;
        ovf_s   = ovf_sub_s;
      end
`else
      OP_SMAX, OP_SMIN: begin
        ill_s = 1'b1;
      end
`endif
      default: begin
        ill_s = 1'b1;
      end
    endcase
  end

  assign zero_s = (res_s == {WIDTH{1'b0}});

  // Stage 1: capture an operand beat whenever the stage can advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 4'd0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_sh_r    <= {SHIFT_W{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r <= opcode;
        s1_a_r  <= input1;
        s1_b_r  <= input2;
        s1_sh_r <= shiftValue;
      end
    end
  end

  // Stage 2: register the result and flags, and hold them under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      ill_r       <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        carry_r  <= carry_s;
        zero_r   <= zero_s;
        ovf_r    <= ovf_s;
        ill_r    <= ill_s;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign result       = result_r;
  assign carryFlag    = carry_r;
  assign zeroFlag     = zero_r;
  assign overFlowFlag = ovf_r;
  assign illegalOp    = ill_r;

endmodule

// File: tb/tb_alu_rotcmp_pipe.sv
// Directed testbench for alu_rotcmp_pipe (WIDTH=8, SHIFT_W=5).
// It covers single beats, streaming, backpressure and reset flush.
module tb_alu_rotcmp_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] input1;
  logic [7:0] input2;
  logic [4:0] shiftValue;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carryFlag;
  logic       zeroFlag;
  logic       overFlowFlag;
  logic       illegalOp;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] sh;
    logic [7:0] res;
    logic [3:0] fl;   // {carry, zero, overflow, illegal}
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  alu_rotcmp_pipe #(.WIDTH(8), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .overFlowFlag(overFlowFlag),
    .illegalOp(illegalOp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [4:0] sh,
                     input logic [7:0] res, input logic [3:0] fl);
    vec_t v;
    v.name = nm; v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.fl = fl;
    vq.push_back(v);
  endtask

  function automatic logic [3:0] flags_now();
    return {carryFlag, zeroFlag, overFlowFlag, illegalOp};
  endfunction

  task automatic drive(input int idx);
    opcode     = vq[idx].op;
    input1     = vq[idx].a;
    input2     = vq[idx].b;
    shiftValue = vq[idx].sh;
  endtask

  task automatic check_out(input string tag, input int idx);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".res"}, 32'(result), 32'(vq[idx].res));
    check_eq({tag, ".flags"}, 32'(flags_now()), 32'(vq[idx].fl));
  endtask

  // One isolated beat: acceptance, one-cycle latency, then consumption.
  task automatic run_single(input int idx);
    drive(idx);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check_eq({vq[idx].name, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({vq[idx].name, ".lat0"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_out(vq[idx].name, idx);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int cur;
    logic rdy;

    add("rol81_1",  4'd0, 8'h81, 8'h00, 5'd1,  8'h03, 4'b1000);
    add("rol81_9",  4'd0, 8'h81, 8'h00, 5'd9,  8'h03, 4'b1000);
    add("ror01_1",  4'd1, 8'h01, 8'h00, 5'd1,  8'h80, 4'b1000);
    add("ror5a_0",  4'd1, 8'h5A, 8'h00, 5'd0,  8'h5A, 4'b0000);
    add("rol00_3",  4'd0, 8'h00, 8'h00, 5'd3,  8'h00, 4'b0100);
    add("max7f80",  4'd2, 8'h7F, 8'h80, 5'd0,  8'h80, 4'b1010);
    add("min7f80",  4'd3, 8'h7F, 8'h80, 5'd0,  8'h7F, 4'b1010);
`ifdef ALU_ROTCMP_SIGNED_EN
    add("smax7f80", 4'd4, 8'h7F, 8'h80, 5'd0,  8'h7F, 4'b1010);
    add("smin7f80", 4'd5, 8'h7F, 8'h80, 5'd0,  8'h80, 4'b1010);
`else
    add("op4ill",   4'd4, 8'h7F, 8'h80, 5'd0,  8'h00, 4'b0101);
    add("op5ill",   4'd5, 8'h7F, 8'h80, 5'd0,  8'h00, 4'b0101);
`endif
    add("op15ill",  4'd15, 8'h12, 8'h34, 5'd2, 8'h00, 4'b0101);
    add("rol96_4",  4'd0, 8'h96, 8'h00, 5'd4,  8'h69, 4'b1000);
    add("ror96_3",  4'd1, 8'h96, 8'h00, 5'd3,  8'hD2, 4'b1000);
    add("ror01_15", 4'd1, 8'h01, 8'h00, 5'd15, 8'h02, 4'b0000);
    add("rol01_31", 4'd0, 8'h01, 8'h00, 5'd31, 8'h80, 4'b0000);
    add("min1020",  4'd3, 8'h10, 8'h20, 5'd0,  8'h10, 4'b1000);
    add("max2010",  4'd2, 8'h20, 8'h10, 5'd0,  8'h20, 4'b0000);
    add("max3333",  4'd2, 8'h33, 8'h33, 5'd0,  8'h33, 4'b0000);
    add("max8001",  4'd2, 8'h80, 8'h01, 5'd0,  8'h80, 4'b0010);
    add("minff01",  4'd3, 8'hFF, 8'h01, 5'd0,  8'h01, 4'b0000);
    add("op6ill",   4'd6, 8'hAA, 8'h55, 5'd1,  8'h00, 4'b0101);
    add("max0000",  4'd2, 8'h00, 8'h00, 5'd0,  8'h00, 4'b0100);

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'd0; input1 = 8'h00; input2 = 8'h00; shiftValue = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.result", 32'(result), 32'd0);
    check_eq("rst.flags", 32'(flags_now()), 32'd0);
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);

    // Each vector in isolation
    for (int i = 0; i < vq.size(); i++) run_single(i);

    // Eight back-to-back beats with the consumer always ready
    out_ready = 1'b1;
    drive(0);
    in_valid = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) check_eq("stream.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (c == 0) check_eq("stream.lat0", 32'(out_valid), 32'd0);
      else check_out($sformatf("stream%0d", c - 1), c - 1);
      if (c + 1 < 8) drive(c + 1);
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("stream.drained", 32'(out_valid), 32'd0);

    // Backpressure: two beats fill the pipe, then everything holds
    out_ready = 1'b0;
    cur = 8;
    acc = 0;
    drive(cur);
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc++;
        cur++;
        drive(cur);
      end
      if (c >= 1) check_out($sformatf("bp.hold%0d", c), 8);
    end
    check_eq("bp.accepted", 32'(acc), 32'd2);
    check_eq("bp.in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_out("bp.drain1", 9);
    @(posedge clk); #1;
    check_eq("bp.empty", 32'(out_valid), 32'd0);

    // Reset with both stages full flushes everything
    out_ready = 1'b0;
    drive(10);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(11);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("flush.full_valid", 32'(out_valid), 32'd1);
    check_eq("flush.full_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("flush.out_valid", 32'(out_valid), 32'd0);
    check_eq("flush.result", 32'(result), 32'd0);
    check_eq("flush.flags", 32'(flags_now()), 32'd0);
    check_eq("flush.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("flush.no_stale", 32'(out_valid), 32'd0);
    end
    run_single(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
